// File: rtl/layer4_argmax.sv
// layer4_argmax: final classification stage after the layer-4 compute block.
// On start_i it reads N_CLASS scores from the layer-4 temp buffer, which has
// one cycle of registered read latency. It tracks the running maximum, where
// a tie keeps the lowest index, and presents the winning class on a
// valid/ready handshake. After the result is taken it pulses temp_clear_o
// for one cycle.
//
// Optional feature: define ARGMAX_TOP2_EN to add second_o, the runner-up
// class index.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   start_i               1-cycle pulse, accepted only in IDLE
//   temp_rd_en_o/addr_o   temp buffer read port (addr is 0 when en is 0)
//   score_i               temp buffer read data (1-cycle latency)
//   temp_clear_o          1-cycle clear pulse after the result handshake
//   busy_o                high whenever the FSM is not in IDLE
//   valid_o/ready_i       result handshake
//   class_o/score_o       argmax index and winning score
//   second_o              runner-up index (ARGMAX_TOP2_EN only)
module layer4_argmax #(
    parameter int unsigned N_CLASS    = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          SIGNED_CMP = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  temp_rd_en_o,
    output logic [5:0]            temp_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] score_i,
    output logic                  temp_clear_o,
    output logic                  busy_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [3:0]            class_o,
`ifdef ARGMAX_TOP2_EN
    output logic [3:0]            second_o,
`endif
    output logic [DATA_WIDTH-1:0] score_o
);

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CLS_W  = 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CLASS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        CLEAR = 3'd4
    } state_e;

    state_e                  state_q;
    logic                    rd_en_q;
    logic [ADDR_W-1:0]       rd_addr_q;
    logic                    clear_q;
    logic                    busy_q;
    logic                    valid_q;
    logic [CLS_W-1:0]        class_q;
    logic [DATA_WIDTH-1:0]   score_q;

    // Read-data qualifier: the read issued last cycle returns data this cycle.
    logic                    samp_q;
    logic [ADDR_W-1:0]       samp_idx_q;

    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic [ADDR_W-1:0]       max_idx_q, max_idx_d;

`ifdef ARGMAX_TOP2_EN
    logic [DATA_WIDTH-1:0]   sec_q, sec_d;
    logic [ADDR_W-1:0]       sec_idx_q, sec_idx_d;
    logic                    sec_vld_q, sec_vld_d;
    logic [CLS_W-1:0]        second_q;
`endif

    // Strict greater-than in the configured number format.
    function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
        if (SIGNED_CMP) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Running max (and runner-up) update for the score arriving this cycle.
    always_comb begin
        max_d     = max_q;
        max_idx_d = max_idx_q;
`ifdef ARGMAX_TOP2_EN
        sec_d     = sec_q;
        sec_idx_d = sec_idx_q;
        sec_vld_d = sec_vld_q;
`endif
        if (samp_q) begin
            if (samp_idx_q == '0) begin
                max_d     = score_i;
                max_idx_d = '0;
`ifdef ARGMAX_TOP2_EN
                sec_d     = '0;
                sec_idx_d = '0;
                sec_vld_d = 1'b0;
`endif
            end else if (gt(score_i, max_q)) begin
`ifdef ARGMAX_TOP2_EN
                sec_d     = max_q;
                sec_idx_d = max_idx_q;
                sec_vld_d = 1'b1;
`endif
                max_d     = score_i;
                max_idx_d = samp_idx_q;
            end
`ifdef ARGMAX_TOP2_EN
            // An empty runner-up slot takes the first non-max score.
            else if (!sec_vld_q || gt(score_i, sec_q)) begin
                sec_d     = score_i;
                sec_idx_d = samp_idx_q;
                sec_vld_d = 1'b1;
            end
`endif
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            score_q    <= '0;
            samp_q     <= 1'b0;
            samp_idx_q <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
`ifdef ARGMAX_TOP2_EN
            sec_q      <= '0;
            sec_idx_q  <= '0;
            sec_vld_q  <= 1'b0;
            second_q   <= '0;
`endif
        end else begin
            samp_q     <= rd_en_q;
            samp_idx_q <= rd_addr_q;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
`ifdef ARGMAX_TOP2_EN
            sec_q      <= sec_d;
            sec_idx_q  <= sec_idx_d;
            sec_vld_q  <= sec_vld_d;
`endif
            clear_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= READ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_q   <= DRAIN;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Last score is folded in via max_d on this same edge.
                    state_q <= OUT;
                    valid_q <= 1'b1;
                    class_q <= CLS_W'(max_idx_d);
                    score_q <= max_d;
`ifdef ARGMAX_TOP2_EN
                    second_q <= CLS_W'(sec_idx_d);
`endif
                end
                OUT: begin
                    if (ready_i) begin
                        state_q <= CLEAR;
                        valid_q <= 1'b0;
                        clear_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    rd_en_q   <= 1'b0;
                    rd_addr_q <= '0;
                    valid_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign temp_rd_en_o   = rd_en_q;
    assign temp_rd_addr_o = rd_addr_q;
    assign temp_clear_o   = clear_q;
    assign busy_o         = busy_q;
    assign valid_o        = valid_q;
    assign class_o        = class_q;
    assign score_o        = score_q;
`ifdef ARGMAX_TOP2_EN
    assign second_o       = second_q;
`endif

endmodule

// File: tb/tb_layer4_argmax.sv
// tb_layer4_argmax: directed and random passes through layer4_argmax. Two
// instances run in lockstep: one compares scores as signed values and one
// compares them as unsigned values. A temp-buffer model feeds both instances,
// and a reference argmax computed from integer score values checks them.
module tb_layer4_argmax;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic       rd_en, u0_rd_en;
    logic [5:0] rd_addr, u0_rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       clr, u0_clr;
    logic       busy, u0_busy;
    logic       valid, u0_valid;
    logic [3:0] cls, u0_cls;
    logic [7:0] sc, u0_sc;
`ifdef ARGMAX_TOP2_EN
    logic [3:0] sec, u0_sec;
`endif

    logic [7:0] mem [N];
    int errs = 0;
    int checks = 0;
    int clr_cnt = 0;
    int rd_cnt = 0;
    int t1 [N] = '{3, 9, 1, 0, 2, 9, 4, 5, 6, 7};
    int t6a [N] = '{1, 8, 3, 8, 7, 0, 0, 0, 0, 0};
    int t6b [N] = '{5, 4, 9, 0, 0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    layer4_argmax #(.N_CLASS(N), .DATA_WIDTH(8), .SIGNED_CMP(1'b1)) u_s (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .temp_rd_en_o(rd_en), .temp_rd_addr_o(rd_addr), .score_i(rd_data),
        .temp_clear_o(clr), .busy_o(busy), .valid_o(valid), .ready_i(ready),
        .class_o(cls),
`ifdef ARGMAX_TOP2_EN
        .second_o(sec),
`endif
        .score_o(sc));

    layer4_argmax #(.N_CLASS(N), .DATA_WIDTH(8), .SIGNED_CMP(1'b0)) u_u (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .temp_rd_en_o(u0_rd_en), .temp_rd_addr_o(u0_rd_addr), .score_i(rd_data),
        .temp_clear_o(u0_clr), .busy_o(u0_busy), .valid_o(u0_valid), .ready_i(ready),
        .class_o(u0_cls),
`ifdef ARGMAX_TOP2_EN
        .second_o(u0_sec),
`endif
        .score_o(u0_sc));

    // Temp buffer: one cycle of registered read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (clr) clr_cnt <= clr_cnt + 1;
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: largest value with the lowest index, and the largest of the
    // remaining scores with the lowest index.
    task automatic ref_model(input bit sgn, output int bi, output int bv, output int si);
        int best, best2, v;
        best = -100000; best2 = -100000; bi = 0; si = 0;
        for (int i = 0; i < N; i++) begin
            v = (sgn && mem[i] >= 8'd128) ? int'(mem[i]) - 256 : int'(mem[i]);
            if (v > best) begin best = v; bi = i; end
        end
        for (int i = 0; i < N; i++) begin
            v = (sgn && mem[i] >= 8'd128) ? int'(mem[i]) - 256 : int'(mem[i]);
            if (i != bi && v > best2) begin best2 = v; si = i; end
        end
        bv = int'(mem[bi]);
    endtask

    task automatic run_pass(input string nm, input int wait_cycles, input bit poke);
        int ei, ev, es, ui, uv, us, clr0, rd0;
        ref_model(1'b1, ei, ev, es);
        ref_model(1'b0, ui, uv, us);
        clr0 = clr_cnt;
        rd0  = rd_cnt;
        check({nm, "_idle_busy"}, 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            check({nm, "_rd_en"}, 32'(rd_en), 32'd1);
            check({nm, "_rd_addr"}, 32'(rd_addr), 32'(k));
            tick();
        end
        check({nm, "_drain_rd_en"}, 32'(rd_en), 32'd0);
        check({nm, "_drain_addr"}, 32'(rd_addr), 32'd0);
        check({nm, "_drain_valid"}, 32'(valid), 32'd0);
        check({nm, "_drain_busy"}, 32'(busy), 32'd1);
        tick();
        check({nm, "_valid"}, 32'(valid), 32'd1);
        check({nm, "_class"}, 32'(cls), 32'(ei));
        check({nm, "_score"}, 32'(sc), 32'(ev));
        check({nm, "_u_valid"}, 32'(u0_valid), 32'd1);
        check({nm, "_u_class"}, 32'(u0_cls), 32'(ui));
        check({nm, "_u_score"}, 32'(u0_sc), 32'(uv));
`ifdef ARGMAX_TOP2_EN
        check({nm, "_second"}, 32'(sec), 32'(es));
        check({nm, "_u_second"}, 32'(u0_sec), 32'(us));
`endif
        for (int w = 0; w < wait_cycles; w++) begin
            ready = 1'b0;
            if (poke && w == wait_cycles / 2) start = 1'b1;
            tick();
            start = 1'b0;
            check({nm, "_hold_valid"}, 32'(valid), 32'd1);
            check({nm, "_hold_class"}, 32'(cls), 32'(ei));
            check({nm, "_hold_score"}, 32'(sc), 32'(ev));
            check({nm, "_hold_clear"}, 32'(clr), 32'd0);
        end
        if (poke) check({nm, "_no_reread"}, 32'(rd_cnt - rd0), 32'(N));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check({nm, "_clr_valid"}, 32'(valid), 32'd0);
        check({nm, "_clr_pulse"}, 32'(clr), 32'd1);
        check({nm, "_clr_busy"}, 32'(busy), 32'd1);
        tick();
        check({nm, "_post_clear"}, 32'(clr), 32'd0);
        check({nm, "_post_busy"}, 32'(busy), 32'd0);
        check({nm, "_clr_count"}, 32'(clr_cnt - clr0), 32'd1);
        check({nm, "_rd_count"}, 32'(rd_cnt - rd0), 32'(N));
        check({nm, "_kept_class"}, 32'(cls), 32'(ei));
        check({nm, "_kept_score"}, 32'(sc), 32'(ev));
    endtask

    initial begin
        int clr0;
        // Reset state
        repeat (3) tick();
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_class", 32'(cls), 32'd0);
        check("rst_clear", 32'(clr), 32'd0);
        rst = 1'b0;
        tick();

        // 1: reference vector
        for (int i = 0; i < N; i++) mem[i] = 8'(t1[i]);
        run_pass("t1", 0, 1'b0);
        // 2: all equal, the tie keeps index 0
        for (int i = 0; i < N; i++) mem[i] = 8'h20;
        run_pass("t2", 3, 1'b0);
        // 3: signed versus unsigned ordering
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        mem[0] = 8'h7F;
        mem[5] = 8'h80;
        run_pass("t3", 1, 1'b0);
        // 4: long backpressure with an ignored start
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        run_pass("t4", 20, 1'b1);

        // 5: reset during READ
        clr0 = clr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rd_en", 32'(rd_en), 32'd0);
        check("t5_addr", 32'(rd_addr), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(valid), 32'd0);
        check("t5_class", 32'(cls), 32'd0);
        check("t5_score", 32'(sc), 32'd0);
        check("t5_clear", 32'(clr), 32'd0);
        tick();
        check("t5_idle_rd_en", 32'(rd_en), 32'd0);
        check("t5_no_clear", 32'(clr_cnt - clr0), 32'd0);
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        run_pass("t5_fresh", 2, 1'b0);

        // 6: runner-up vectors
        for (int i = 0; i < N; i++) mem[i] = 8'(t6a[i]);
        run_pass("t6a", 0, 1'b0);
        for (int i = 0; i < N; i++) mem[i] = 8'(t6b[i]);
        run_pass("t6b", 0, 1'b0);

        // Random passes, some drawn from a narrow range to force ties
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++)
                mem[i] = (r % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3) << 6);
            run_pass("rnd", int'($urandom_range(0, 4)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
